// File: rtl/dram_burst_xfer_if.sv
// Bus bundle for the DQ/DQS/DM_n burst engine.
// master = requester/pin model side, slave = engine side.
interface dram_burst_xfer_if #(
  parameter int WORD_W = 32,
  parameter int BL     = 8
);
  localparam int COL_W = $clog2(BL);
  localparam int NBYTE = WORD_W / 8;

  logic              clear;
  logic              wr_req;
  logic              rd_req;
  logic [COL_W-1:0]  col;
  logic [WORD_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [COL_W-1:0]  wr_beat_idx;
  logic [WORD_W-1:0] dq_out;
  logic              dq_oe;
  logic [WORD_W-1:0] dq_in;
  logic              dqs_t_out;
  logic              dqs_c_out;
  logic              dqs_t_in;
  logic              dqs_c_in;
  logic [NBYTE-1:0]  dm_n_out;
  logic [NBYTE-1:0]  dm_n_in;
  logic [WORD_W-1:0] rd_data;
  logic              rd_valid;
  logic [COL_W-1:0]  rd_idx;
  logic              rd_last;
  logic              edge_flag;
  logic              busy;
  logic              done;
  logic              err_underrun;
  logic              err_timeout;

  modport master (
    output clear, wr_req, rd_req, col,
    output wr_data, wr_valid,
    output dq_in, dqs_t_in, dqs_c_in, dm_n_in,
    input  wr_ready, wr_beat_idx,
    input  dq_out, dq_oe, dqs_t_out, dqs_c_out,
    input  dm_n_out, rd_data, rd_valid, rd_idx,
    input  rd_last, edge_flag, busy, done,
    input  err_underrun, err_timeout
  );

  modport slave (
    input  clear, wr_req, rd_req, col,
    input  wr_data, wr_valid,
    input  dq_in, dqs_t_in, dqs_c_in, dm_n_in,
    output wr_ready, wr_beat_idx,
    output dq_out, dq_oe, dqs_t_out, dqs_c_out,
    output dm_n_out, rd_data, rd_valid, rd_idx,
    output rd_last, edge_flag, busy, done,
    output err_underrun, err_timeout
  );
endinterface

// File: rtl/dram_burst_xfer.sv
// DRAM DQ burst engine: wrapped write bursts, DQS-captured reads.
// Define DRAM_XFER_DBI_EN to turn DM_n into DBI_n.
module dram_burst_xfer #(
  parameter int WORD_W     = 32,
  parameter int BL         = 8,
  parameter int RD_TIMEOUT = 16
) (
  input logic              CLK,
  input logic              RST,
  dram_burst_xfer_if.slave bus
);
  localparam int COL_W = $clog2(BL);
  localparam int NBYTE = WORD_W / 8;
  localparam int TMO_W = $clog2(RD_TIMEOUT + 1);
  localparam logic [COL_W-1:0] LAST =
    COL_W'(BL - 1);
  localparam logic [TMO_W-1:0] TMO_END =
    TMO_W'(RD_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, WR_PRE, WR_BURST,
    WR_POST, RD_WAIT, RD_BURST
  } state_t;

  state_t            state_q, state_d;
  logic [COL_W-1:0]  col_q, beat_q, idx;
  logic [TMO_W-1:0]  tmo_q;
  logic              dqs_prev_q;
  logic              rise, toggle;
  logic              rd_valid_q, rd_last_q;
  logic [WORD_W-1:0] rd_data_q, rd_word;
  logic [COL_W-1:0]  rd_idx_q;
  logic              done_q, err_ur_q, err_to_q;
  logic              dq_oe, dqs_t, wr_ready, wr_edge;
  logic [WORD_W-1:0] dq_out;
  logic [NBYTE-1:0]  dm_n;
  logic [COL_W-1:0]  wr_idx;
  logic              unused_in;

`ifdef DRAM_XFER_DBI_EN
  assign unused_in = bus.dqs_c_in;
`else
  assign unused_in = ^{bus.dqs_c_in, bus.dm_n_in};
`endif

  assign idx    = col_q + beat_q;
  assign rise   = bus.dqs_t_in & ~dqs_prev_q;
  assign toggle = bus.dqs_t_in ^ dqs_prev_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (bus.wr_req)      state_d = WR_PRE;
        else if (bus.rd_req) state_d = RD_WAIT;
      WR_PRE:   state_d = WR_BURST;
      WR_BURST: if (beat_q == LAST) state_d = WR_POST;
      WR_POST:  state_d = IDLE;
      RD_WAIT:
        if (rise)                   state_d = RD_BURST;
        else if (tmo_q == TMO_END)  state_d = IDLE;
      RD_BURST: if (rd_last_q) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Pin drive is a pure function of state and the upstream beat.
  always_comb begin
    dq_oe    = 1'b0;
    dq_out   = '0;
    dqs_t    = 1'b0;
    dm_n     = '1;
    wr_ready = 1'b0;
    wr_idx   = '0;
    wr_edge  = 1'b0;
    unique case (state_q)
      WR_PRE, WR_POST: dq_oe = 1'b1;
      WR_BURST: begin
        dq_oe    = 1'b1;
        dqs_t    = ~beat_q[0];
        wr_idx   = idx;
        wr_edge  = 1'b1;
        wr_ready = bus.wr_valid;
        if (bus.wr_valid) begin
          dq_out = bus.wr_data;
`ifdef DRAM_XFER_DBI_EN
          for (int i = 0; i < NBYTE; i++) begin
            if ($countones(bus.wr_data[8*i +: 8]) > 4) begin
              dq_out[8*i +: 8] = ~bus.wr_data[8*i +: 8];
              dm_n[i] = 1'b0;
            end
          end
`endif
        end else begin
`ifndef DRAM_XFER_DBI_EN
          dm_n = '0;
`endif
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_word = bus.dq_in;
`ifdef DRAM_XFER_DBI_EN
    for (int i = 0; i < NBYTE; i++) begin
      if (!bus.dm_n_in[i])
        rd_word[8*i +: 8] = ~bus.dq_in[8*i +: 8];
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST || bus.clear) begin
      state_q    <= IDLE;
      col_q      <= '0;
      beat_q     <= '0;
      tmo_q      <= '0;
      dqs_prev_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
      rd_idx_q   <= '0;
      done_q     <= 1'b0;
      err_ur_q   <= 1'b0;
      err_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      dqs_prev_q <= bus.dqs_t_in;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      done_q     <= 1'b0;
      unique case (state_q)
        IDLE: begin
          beat_q <= '0;
          tmo_q  <= '0;
          if (bus.wr_req || bus.rd_req)
            col_q <= bus.col;
        end
        WR_BURST: begin
          beat_q <= beat_q + 1'b1;
          if (!bus.wr_valid) err_ur_q <= 1'b1;
        end
        WR_POST: done_q <= 1'b1;
        RD_WAIT: begin
          tmo_q <= tmo_q + 1'b1;
          if (rise) begin
            rd_valid_q <= 1'b1;
            rd_data_q  <= rd_word;
            rd_idx_q   <= idx;
            rd_last_q  <= (beat_q == LAST);
            beat_q     <= beat_q + 1'b1;
          end else if (tmo_q == TMO_END) begin
            err_to_q <= 1'b1;
            tmo_q    <= '0;
          end
        end
        // rd_last cycle is a drain cycle; done follows it.
        RD_BURST: begin
          if (rd_last_q) begin
            done_q <= 1'b1;
          end else if (toggle) begin
            rd_valid_q <= 1'b1;
            rd_data_q  <= rd_word;
            rd_idx_q   <= idx;
            rd_last_q  <= (beat_q == LAST);
            beat_q     <= beat_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.dq_oe        = dq_oe;
  assign bus.dq_out       = dq_out;
  assign bus.dqs_t_out    = dqs_t;
  assign bus.dqs_c_out    = ~dqs_t;
  assign bus.dm_n_out     = dm_n;
  assign bus.wr_ready     = wr_ready;
  assign bus.wr_beat_idx  = wr_idx;
  assign bus.rd_data      = rd_data_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.rd_idx       = rd_idx_q;
  assign bus.rd_last      = rd_last_q;
  assign bus.edge_flag    = wr_edge | rd_valid_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = done_q;
  assign bus.err_underrun = err_ur_q;
  assign bus.err_timeout  = err_to_q;
endmodule

// File: tb/tb_dram_burst_xfer.sv
// Randomized bench for dram_burst_xfer against a beat-level model.
// Honours DRAM_XFER_DBI_EN the same way the design does.
module tb_dram_burst_xfer;
  localparam int W  = 32;
  localparam int BL = 8;
  localparam int CW = 3;
  localparam int NB = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   exp_ur = 0;
  bit   exp_to = 0;

  always #5 clk = ~clk;

  dram_burst_xfer_if #(.WORD_W(W), .BL(BL)) bus ();

  dram_burst_xfer #(
    .WORD_W(W), .BL(BL), .RD_TIMEOUT(16)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic void wr_model(
    input  logic [W-1:0]  d,
    input  bit            v,
    output logic [W-1:0]  dq,
    output logic [NB-1:0] dm);
    dq = '0;
    dm = '1;
    if (!v) begin
`ifndef DRAM_XFER_DBI_EN
      dm = '0;
`endif
      return;
    end
    dq = d;
`ifdef DRAM_XFER_DBI_EN
    for (int i = 0; i < NB; i++) begin
      int ones;
      ones = 0;
      for (int b = 0; b < 8; b++) ones += int'(d[8*i+b]);
      if (ones > 4) begin
        dq[8*i +: 8] = ~d[8*i +: 8];
        dm[i] = 1'b0;
      end
    end
`endif
  endfunction

  function automatic logic [W-1:0] pin_word(
    input logic [W-1:0] d, input logic [NB-1:0] dm);
    logic [W-1:0] r;
    r = d;
`ifdef DRAM_XFER_DBI_EN
    for (int i = 0; i < NB; i++)
      if (!dm[i]) r[8*i +: 8] = ~d[8*i +: 8];
`endif
    return r;
  endfunction

  task automatic idle_chk();
    chk("idle_oe",   bus.dq_oe, 0);
    chk("idle_dq",   bus.dq_out, 0);
    chk("idle_dqs",  {bus.dqs_t_out, bus.dqs_c_out}, 2'b01);
    chk("idle_dm",   bus.dm_n_out, 4'hF);
    chk("idle_rdy",  bus.wr_ready, 0);
    chk("idle_widx", bus.wr_beat_idx, 0);
    chk("idle_rd",   {bus.rd_valid, bus.rd_last, bus.rd_idx}, 0);
    chk("idle_rdat", bus.rd_data, 0);
    chk("idle_edge", bus.edge_flag, 0);
    chk("idle_busy", bus.busy, 0);
    chk("idle_done", bus.done, 0);
    chk("idle_err",  {bus.err_underrun, bus.err_timeout}, 0);
  endtask

  task automatic do_write(input logic [CW-1:0] c0,
                          input logic [BL-1:0] vmask,
                          input bit            seq,
                          input bit            both,
                          input logic [W-1:0]  fixed);
    logic [W-1:0]  data [BL];
    logic [W-1:0]  edq;
    logic [NB-1:0] edm;
    logic [CW-1:0] idx;
    for (int i = 0; i < BL; i++)
      data[i] = seq ? 32'h1000_0000 + W'(i) :
                (fixed != 0) ? fixed : W'($urandom);
    @(posedge clk); #1;
    bus.wr_req = 1'b1;
    bus.rd_req = both;
    bus.col    = c0;
    @(negedge clk);
    chk("req_busy", bus.busy, 0);
    @(posedge clk); #1;
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    @(negedge clk);
    chk("pre_oe",  bus.dq_oe, 1);
    chk("pre_dqs", {bus.dqs_t_out, bus.dqs_c_out}, 2'b01);
    chk("pre_dq",  bus.dq_out, 0);
    for (int k = 0; k < BL; k++) begin
      @(posedge clk); #1;
      idx = CW'((int'(c0) + k) % BL);
      bus.wr_valid = vmask[k];
      bus.wr_data  = vmask[k] ? data[idx] : W'($urandom);
      wr_model(data[idx], vmask[k], edq, edm);
      @(negedge clk);
      chk("wr_idx",  bus.wr_beat_idx, idx);
      chk("wr_dqs",  {bus.dqs_t_out, bus.dqs_c_out},
          (k % 2 == 0) ? 2'b10 : 2'b01);
      chk("wr_dq",   bus.dq_out, edq);
      chk("wr_dm",   bus.dm_n_out, edm);
      chk("wr_rdy",  bus.wr_ready, vmask[k]);
      chk("wr_edge", bus.edge_flag, 1);
      if (!vmask[k]) exp_ur = 1;
    end
    @(posedge clk); #1;
    bus.wr_valid = 1'b0;
    @(negedge clk);
    chk("post_oe",   bus.dq_oe, 1);
    chk("post_dqs",  {bus.dqs_t_out, bus.dqs_c_out}, 2'b01);
    chk("post_done", bus.done, 0);
    chk("post_ur",   bus.err_underrun, exp_ur);
    @(negedge clk);
    chk("wdone",      bus.done, 1);
    chk("wdone_oe",   bus.dq_oe, 0);
    chk("wdone_busy", bus.busy, 0);
    @(negedge clk);
    chk("wdone_pls",  bus.done, 0);
    chk("w_no_rd",    {bus.busy, bus.rd_valid}, 0);
  endtask

  task automatic do_read(input logic [CW-1:0] c0,
                         input int            gap_pct,
                         input int            bubble_n,
                         input bit            seq,
                         input logic [W-1:0]  fixed);
    int            n, last_t, wait_c;
    bit            dqs, cap, pv, plast, bubbled, fin;
    logic [W-1:0]  pd, word;
    logic [CW-1:0] pi;
    logic [NB-1:0] dm;
    @(posedge clk); #1;
    bus.rd_req   = 1'b1;
    bus.col      = c0;
    bus.dqs_t_in = 1'b0;
    bus.dqs_c_in = 1'b1;
    @(posedge clk); #1;
    bus.rd_req = 1'b0;
    wait_c  = $urandom_range(0, 5);
    n       = 0;
    dqs     = 0;
    pv      = 0;
    plast   = 0;
    pd      = '0;
    pi      = '0;
    last_t  = -10;
    bubbled = 0;
    fin     = 0;
    for (int t = 0; t < 200; t++) begin
      if (t > 0) begin @(posedge clk); #1; end
      cap = (t >= wait_c) && (n < BL);
      if (cap && n > 0 && $urandom_range(0, 99) < gap_pct)
        cap = 0;
      if (cap && n == bubble_n && !bubbled) begin
        cap = 0;
        bubbled = 1;
      end
      word = seq ? 32'hA0 + W'(n) :
             (fixed != 0) ? fixed : W'($urandom);
      dm = (fixed != 0) ? 4'b0111 : NB'($urandom);
      if (cap) begin
        dqs = ~dqs;
        bus.dq_in   = pin_word(word, dm);
        bus.dm_n_in = dm;
      end else begin
        bus.dq_in   = W'($urandom);
        bus.dm_n_in = NB'($urandom);
      end
      bus.dqs_t_in = dqs;
      bus.dqs_c_in = ~dqs;
      @(negedge clk);
      chk("rd_vld",  bus.rd_valid, pv);
      chk("rd_edge", bus.edge_flag, pv);
      if (pv) begin
        chk("rd_data", bus.rd_data, pd);
        chk("rd_idx",  bus.rd_idx, pi);
        chk("rd_last", bus.rd_last, plast);
      end
      chk("rd_done", bus.done, (t == last_t + 2));
      chk("rd_busy", bus.busy, (t != last_t + 2));
      if (t == last_t + 2) begin
        fin = 1;
        break;
      end
      pv = cap;
      if (cap) begin
        pd    = word;
        pi    = CW'((int'(c0) + n) % BL);
        plast = (n == BL - 1);
        if (n == BL - 1) last_t = t;
        n++;
      end
    end
    chk("rd_end", fin, 1);
  endtask

  task automatic do_timeout();
    @(posedge clk); #1;
    bus.rd_req   = 1'b1;
    bus.col      = CW'($urandom);
    bus.dqs_t_in = 1'b0;
    bus.dqs_c_in = 1'b1;
    @(posedge clk); #1;
    bus.rd_req = 1'b0;
    for (int t = 0; t <= 16; t++) begin
      if (t > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      chk("to_vld", bus.rd_valid, 0);
      if (t == 15) begin
        chk("to_early", bus.err_timeout, exp_to);
        chk("to_busy",  bus.busy, 1);
      end
      if (t == 16) begin
        chk("to_flag", bus.err_timeout, 1);
        chk("to_idle", bus.busy, 0);
        chk("to_done", bus.done, 0);
      end
    end
    exp_to = 1;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1;
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    exp_ur = 0;
    exp_to = 0;
    @(negedge clk);
    idle_chk();
  endtask

  task automatic clear_mid_write();
    @(posedge clk); #1;
    bus.wr_req = 1'b1;
    bus.col    = CW'($urandom);
    @(posedge clk); #1;
    bus.wr_req   = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = W'($urandom);
    repeat (3) @(posedge clk);
    #1;
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    exp_ur = 0;
    exp_to = 0;
    @(negedge clk);
    idle_chk();
    repeat (3) begin
      @(negedge clk);
      chk("clr_done", bus.done, 0);
    end
    bus.wr_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    bus.clear    = 1'b0;
    bus.wr_req   = 1'b0;
    bus.rd_req   = 1'b0;
    bus.col      = '0;
    bus.wr_data  = '0;
    bus.wr_valid = 1'b0;
    bus.dq_in    = '0;
    bus.dqs_t_in = 1'b0;
    bus.dqs_c_in = 1'b1;
    bus.dm_n_in  = '1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    idle_chk();

    do_write(3'd0, 8'hFF, 1, 0, '0);
    do_write(3'd5, 8'hFF, 0, 0, '0);
    do_write(3'd2, 8'hF7, 0, 0, '0);
    do_write(3'd6, 8'hFF, 0, 0, '0);
    pulse_clear();

    do_read(3'd2, 0, 5, 1, '0);
    do_write(3'd1, 8'hFF, 0, 0, 32'hFF0F_00F8);
    do_read(3'd7, 0, -1, 0, 32'hFF0F_00F8);

    do_timeout();
    do_write(3'd4, 8'hFF, 0, 1, '0);
    pulse_clear();

    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(0, 1) == 1)
        do_write(CW'($urandom),
                 ($urandom_range(0, 2) == 0) ?
                   BL'($urandom) : 8'hFF,
                 0, 0, '0);
      else
        do_read(CW'($urandom), 25, -1, 0, '0);
    end

    clear_mid_write();

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end
endmodule
